// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB4 to register-bus bridge.
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned LegalDataWidths [2] = '{32, 64};

    // Wide enough to hold TimeoutCycles itself; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        if (timeout_cycles == 0) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_to_reg_bridge.sv
// APB4 slave to register-bus master bridge; requests and responses are all registered,
// with byte strobes, an optional privilege filter and a downstream timeout.
//
//   state | meaning
//   IDLE  | waiting for an APB access phase
//   REQ   | reg_valid_o high, waiting for reg_ready_i or timeout
//   RESP  | one-cycle pready_o pulse carrying captured rdata/err
module apb_to_reg_bridge
    import apb_reg_pkg::*;
#(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter bit          PrivOnly      = 1'b0,
    localparam int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [DataWidth-1:0] pwdata_i,
    input  logic [StrbWidth-1:0] pstrb_i,
    input  logic [2:0]           pprot_i,
    output logic [DataWidth-1:0] prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 reg_valid_o,
    output logic                 reg_write_o,
    output logic [AddrWidth-1:0] reg_addr_o,
    output logic [DataWidth-1:0] reg_wdata_o,
    output logic [StrbWidth-1:0] reg_wstrb_o,
    input  logic                 reg_ready_i,
    input  logic [DataWidth-1:0] reg_rdata_i,
    input  logic                 reg_error_i
);

    localparam int unsigned CntWidth = cnt_width(TimeoutCycles);
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);

    if (DataWidth != LegalDataWidths[0] && DataWidth != LegalDataWidths[1]) begin : g_bad_width
        $error("apb_to_reg_bridge: DataWidth must be 32 or 64");
    end

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic                   unused_prot;

    assign unused_prot = ^pprot_i[2:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (psel_i && penable_i) begin
                    if (PrivOnly && !pprot_i[0]) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        addr_d  = paddr_i;
                        write_d = pwrite_i;
                        wdata_d = pwdata_i;
                        wstrb_d = pwrite_i ? pstrb_i : '0;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (reg_ready_i) begin
                    rdata_d = write_q ? '0 : reg_rdata_i;
                    err_d   = reg_error_i;
                    state_d = RESP;
                end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        valid_d   = (state_d == REQ);
        pready_d  = (state_d == RESP);
        pslverr_d = (state_d == RESP) && err_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign reg_valid_o = valid_q;
    assign reg_write_o = write_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;
    assign prdata_o    = rdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;

endmodule

// File: tb/tb_apb_to_reg_bridge.sv
// Directed bench for apb_to_reg_bridge: table of APB transfers plus hand sequences
// for stray ready and reset during a pending request.
module tb_apb_to_reg_bridge;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          psel_i = 1'b0;
    logic          penable_i = 1'b0;
    logic          pwrite_i = 1'b0;
    logic [AW-1:0] paddr_i = '0;
    logic [DW-1:0] pwdata_i = '0;
    logic [SW-1:0] pstrb_i = '0;
    logic [2:0]    pprot_i = '0;
    logic [DW-1:0] prdata_o;
    logic          pready_o;
    logic          pslverr_o;
    logic          reg_valid_o;
    logic          reg_write_o;
    logic [AW-1:0] reg_addr_o;
    logic [DW-1:0] reg_wdata_o;
    logic [SW-1:0] reg_wstrb_o;
    logic          reg_ready_i = 1'b0;
    logic [DW-1:0] reg_rdata_i = '0;
    logic          reg_error_i = 1'b0;

    apb_to_reg_bridge #(
        .AddrWidth     (AW),
        .DataWidth     (DW),
        .TimeoutCycles (8),
        .PrivOnly      (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .psel_i      (psel_i),
        .penable_i   (penable_i),
        .pwrite_i    (pwrite_i),
        .paddr_i     (paddr_i),
        .pwdata_i    (pwdata_i),
        .pstrb_i     (pstrb_i),
        .pprot_i     (pprot_i),
        .prdata_o    (prdata_o),
        .pready_o    (pready_o),
        .pslverr_o   (pslverr_o),
        .reg_valid_o (reg_valid_o),
        .reg_write_o (reg_write_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            delay;      // valid cycles before ready; large = never
        logic [DW-1:0] rdata;
        logic          err;
        int            exp_vcnt;
        int            exp_lat;    // access-phase cycle through pready cycle, inclusive
        logic [DW-1:0] exp_prdata;
        logic          exp_err;
        logic [SW-1:0] exp_wstrb;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int  vcnt;
        int  bad;
        int  lat;
        int  first_v;
        logic done;
        logic [DW-1:0] got_rdata;
        logic got_err;
        vcnt = 0; bad = 0; lat = 0; first_v = 0; done = 1'b0;
        got_rdata = '0; got_err = 1'b0;

        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0;
        pwrite_i = v.write; paddr_i = v.addr; pwdata_i = v.wdata;
        pstrb_i = v.strb; pprot_i = v.prot;
        reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
        @(negedge clk_i);
        penable_i = 1'b1;

        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk_i);
            #1;
            reg_ready_i = 1'b0;
            reg_error_i = 1'b0;
            reg_rdata_i = '0;
            if (reg_valid_o) begin
                vcnt++;
                if (first_v == 0) first_v = cyc;
                if (reg_addr_o !== v.addr || reg_write_o !== v.write ||
                    reg_wdata_o !== v.wdata || reg_wstrb_o !== v.exp_wstrb) bad++;
                if (vcnt - 1 == v.delay) begin
                    reg_ready_i = 1'b1;
                    reg_error_i = v.err;
                    reg_rdata_i = v.rdata;
                end
            end
            if (pready_o) begin
                done = 1'b1;
                lat = cyc + 1;
                got_rdata = prdata_o;
                got_err = pslverr_o;
            end
        end

        chk($sformatf("v%0d_done", idx), done, 1'b1);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_valid_cycles", idx), vcnt, v.exp_vcnt);
        chk($sformatf("v%0d_req_stable", idx), bad, 0);
        chk($sformatf("v%0d_prdata", idx), got_rdata, v.exp_prdata);
        chk($sformatf("v%0d_pslverr", idx), got_err, v.exp_err);
        if (v.exp_vcnt > 0) chk($sformatf("v%0d_first_valid", idx), first_v, 1);

        @(posedge clk_i);
        #1;
        chk($sformatf("v%0d_pready_one_cycle", idx), pready_o, 1'b0);
        psel_i = 1'b0; penable_i = 1'b0;
        reg_ready_i = 1'b0; reg_error_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        vecs[0] = '{1'b1, 64'h1000, 32'hDEADBEEF, 4'hF, 3'b001, 0, 32'hFFFFFFFF, 1'b0,
                    1, 3, 32'h0, 1'b0, 4'hF};
        vecs[1] = '{1'b0, 64'h2004, 32'h0, 4'hF, 3'b001, 5, 32'h12345678, 1'b0,
                    6, 8, 32'h12345678, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 64'h3000, 32'h0, 4'hF, 3'b000, 0, 32'h55555555, 1'b0,
                    0, 2, 32'h0, 1'b1, 4'h0};
        vecs[3] = '{1'b0, 64'h3000, 32'h0, 4'hF, 3'b001, 0, 32'hAAAA5555, 1'b0,
                    1, 3, 32'hAAAA5555, 1'b0, 4'h0};
        vecs[4] = '{1'b1, 64'h4008, 32'h0000BEEF, 4'h3, 3'b011, 1, 32'h77777777, 1'b0,
                    2, 4, 32'h0, 1'b0, 4'h3};
        vecs[5] = '{1'b0, 64'h400C, 32'h0, 4'hF, 3'b001, 0, 32'hCAFE0001, 1'b1,
                    1, 3, 32'hCAFE0001, 1'b1, 4'h0};
        vecs[6] = '{1'b0, 64'h5000, 32'h0, 4'hF, 3'b001, 99, 32'h0, 1'b0,
                    8, 10, 32'h0, 1'b1, 4'h0};
        vecs[7] = '{1'b1, 64'h6000, 32'h00C0FFEE, 4'hC, 3'b101, 2, 32'h0, 1'b1,
                    3, 5, 32'h0, 1'b1, 4'hC};
        vecs[8] = '{1'b0, 64'hFFFF000012345677, 32'h0, 4'hF, 3'b001, 7, 32'h0F0F0F0F, 1'b0,
                    8, 10, 32'h0F0F0F0F, 1'b0, 4'h0};

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_pready", pready_o, 1'b0);
        chk("reset_valid", reg_valid_o, 1'b0);
        chk("reset_outputs", {prdata_o, pslverr_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o} == '0, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < NV; i++) begin
            run_xfer(vecs[i], i);
        end

        // Stray ready after a timeout must not produce a response or new data.
        run_xfer(vecs[6], 60);
        reg_ready_i = 1'b1; reg_rdata_i = 32'hBAD0BAD0; reg_error_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("stray_pready_%0d", k), pready_o, 1'b0);
            chk($sformatf("stray_prdata_%0d", k), prdata_o, 32'h0);
        end
        reg_ready_i = 1'b0; reg_rdata_i = '0; reg_error_i = 1'b0;

        // Leave a non-zero prdata behind, then reset during a pending request.
        run_xfer(vecs[5], 50);
        chk("prdata_held_idle", prdata_o, 32'hCAFE0001);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 64'h7777;
        pwdata_i = 32'h13579BDF; pstrb_i = 4'hF; pprot_i = 3'b001;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_seq_in_req", reg_valid_o, 1'b1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", reg_valid_o, 1'b0);
        chk("rst_prdata", prdata_o, 32'h0);
        chk("rst_req_fields", {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o} == '0, 1'b1);
        chk("rst_resp", {pready_o, pslverr_o}, 2'b00);
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_xfer(vecs[3], 70);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
